// File: rtl/lag_line_pkg.sv
// Shared types and helpers for the lag line stream: FSM states, index-width
// derivation and the rule that unwritten history reads back as zero.
package lag_line_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Width of a lag/tap index for a history of the given depth.
    function automatic int lw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // An entry of the given age holds real data only once that many samples exist.
    function automatic logic age_valid(input int unsigned age, input int unsigned fill);
        return age < fill;
    endfunction

endpackage

// File: rtl/lag_line_stream_if.sv
// Sample input and tap stream bundle of the lag line. The slave modport is the
// lag line itself; the master modport is the converter/estimator side.
interface lag_line_stream_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
);
    import lag_line_pkg::*;

    localparam int LW = lw_of(DEPTH);

    logic             enable;
    logic [WIDTH-1:0] signal;
    logic [LW-1:0]    lag_sel;
    logic [WIDTH-1:0] signal_align;
    logic             tap_valid;
    logic             tap_ready;
    logic [WIDTH-1:0] tap_data;
    logic [LW-1:0]    tap_index;
    logic             tap_last;
    logic             ready;

    modport slave (
        input  enable,
        input  signal,
        input  lag_sel,
        input  tap_ready,
        output signal_align,
        output tap_valid,
        output tap_data,
        output tap_index,
        output tap_last,
        output ready
    );

    modport master (
        output enable,
        output signal,
        output lag_sel,
        output tap_ready,
        input  signal_align,
        input  tap_valid,
        input  tap_data,
        input  tap_index,
        input  tap_last,
        input  ready
    );

endinterface

// File: rtl/lag_ring_buffer.sv
// DEPTH-deep sample history with one write port and two read ports addressed
// by age, where age 0 is the most recently written sample.
module lag_ring_buffer import lag_line_pkg::*; #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 16,
    localparam int LW    = lw_of(DEPTH)
) (
    input  logic             clk_operation,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LW-1:0]    align_age,
    output logic [WIDTH-1:0] align_data,
    input  logic [LW-1:0]    tap_age,
    output logic [WIDTH-1:0] tap_data,
    output logic [LW:0]      fill_count
);

    localparam logic [LW:0] FULL = (LW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    align_idx;
    logic [LW-1:0]    tap_idx;

    // Storage is deliberately left out of reset; fill_count masks stale entries.
    always_ff @(posedge clk_operation) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            fill_count <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + LW'(1);
            if (fill_count != FULL) begin
                fill_count <= fill_count + (LW+1)'(1);
            end
        end
    end

    // DEPTH is a power of two, so the pointer arithmetic wraps for free.
    assign align_idx  = wr_ptr - LW'(1) - align_age;
    assign tap_idx    = wr_ptr - LW'(1) - tap_age;

    assign align_data = age_valid(32'(align_age), 32'(fill_count)) ? mem[align_idx] : '0;
    assign tap_data   = age_valid(32'(tap_age), 32'(fill_count)) ? mem[tap_idx] : '0;

endmodule

// File: rtl/lag_line_stream.sv
// Lag line: records strobed samples into a ring history, emits a lag-aligned
// copy of each sample and streams a TAPS-long reference vector per sample.
module lag_line_stream import lag_line_pkg::*; #(
    parameter int  WIDTH = 64,
    parameter int  TAPS  = 4,
    parameter int  DEPTH = 16,
    localparam int LW    = lw_of(DEPTH)
) (
    input  logic             clk_operation,
    input  logic             rst_n,
    input  logic             overrun_clr,
    lag_line_stream_if.slave bus,
    output logic             busy,
    output logic             overrun,
    output logic [LW:0]      fill_count
);

    localparam logic [LW-1:0] LAST_IDX = LW'(TAPS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] align_q;
    logic [WIDTH-1:0] align_d;
    logic [WIDTH-1:0] tap_data_q;
    logic [WIDTH-1:0] tap_data_d;
    logic [LW-1:0]    tap_index_q;
    logic [LW-1:0]    tap_index_d;
    logic             tap_valid_q;
    logic             tap_valid_d;
    logic             ready_q;
    logic             ready_d;
    logic             overrun_q;
    logic             overrun_d;

    logic             wr_en;
    logic [LW-1:0]    align_age;
    logic [LW-1:0]    tap_age;
    logic [WIDTH-1:0] ring_align_data;
    logic [WIDTH-1:0] ring_tap_data;
    logic             handshake;
    logic             at_last;

    // Reads happen before the incoming sample lands, so lag L sits at ring age L-1
    // and the next tap k+1 sits at ring age k+1 once the sample has been written.
    assign align_age = bus.lag_sel - LW'(1);
    assign tap_age   = tap_index_q + LW'(1);
    assign handshake = tap_valid_q && bus.tap_ready;
    assign at_last   = (tap_index_q == LAST_IDX);

    lag_ring_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_operation (clk_operation),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_data       (bus.signal),
        .align_age     (align_age),
        .align_data    (ring_align_data),
        .tap_age       (tap_age),
        .tap_data      (ring_tap_data),
        .fill_count    (fill_count)
    );

    always_comb begin
        state_d     = state_q;
        align_d     = align_q;
        tap_data_d  = tap_data_q;
        tap_index_d = tap_index_q;
        tap_valid_d = tap_valid_q;
        ready_d     = 1'b0;
        overrun_d   = overrun_q;
        wr_en       = 1'b0;

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    wr_en       = 1'b1;
                    align_d     = (bus.lag_sel == '0) ? bus.signal : ring_align_data;
                    tap_data_d  = bus.signal;
                    tap_index_d = '0;
                    tap_valid_d = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                // A strobe here is lost; setting overrun beats a same-cycle clear.
                if (bus.enable) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    if (at_last) begin
                        tap_valid_d = 1'b0;
                        ready_d     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        tap_index_d = tap_index_q + LW'(1);
                        tap_data_d  = ring_tap_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            align_q     <= '0;
            tap_data_q  <= '0;
            tap_index_q <= '0;
            tap_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_q     <= align_d;
            tap_data_q  <= tap_data_d;
            tap_index_q <= tap_index_d;
            tap_valid_q <= tap_valid_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.signal_align = align_q;
    assign bus.tap_valid    = tap_valid_q;
    assign bus.tap_data     = tap_data_q;
    assign bus.tap_index    = tap_index_q;
    assign bus.tap_last     = tap_valid_q && at_last;
    assign bus.ready        = ready_q;
    assign busy             = (state_q != IDLE);
    assign overrun          = overrun_q;

endmodule
